// File: rtl/alu_serial_seq_if.sv
// Operation request/response and 1-bit ALU slice signals of the bit-serial sequencer.
// The master is the requester and slice owner; the slave is alu_serial_seq.
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;
  logic             sl_src1_o;
  logic             sl_src2_o;
  logic             sl_less_o;
  logic             sl_ainv_o;
  logic             sl_binv_o;
  logic             sl_cin_o;
  logic [1:0]       sl_op_o;
  logic             sl_result_i;
  logic             sl_cout_i;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o,
    input  sl_src1_o, sl_src2_o, sl_less_o, sl_ainv_o, sl_binv_o, sl_cin_o, sl_op_o,
    output sl_result_i, sl_cout_i
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o,
    output sl_src1_o, sl_src2_o, sl_less_o, sl_ainv_o, sl_binv_o, sl_cin_o, sl_op_o,
    input  sl_result_i, sl_cout_i
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer: drives a single 1-bit ALU slice LSB first and assembles
// the WIDTH-bit result and flags; SLT takes a second pass to place the less bit.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_serial_seq_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SLT2, DONE} state_t;

  // {valid, ainv, binv, op[1:0], initial cin}
  function automatic logic [5:0] decode(input logic [3:0] c);
    case (c)
      4'b0000: decode = 6'b1_0_0_00_0;
      4'b0001: decode = 6'b1_0_0_01_0;
      4'b0010: decode = 6'b1_0_0_10_0;
      4'b0110: decode = 6'b1_0_1_10_1;
      4'b0111: decode = 6'b1_0_1_10_1;
      4'b1100: decode = 6'b1_1_1_00_0;
      4'b1101: decode = 6'b1_1_1_01_0;
      default: decode = 6'b0_0_0_00_0;
    endcase
  endfunction

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [3:0]       ctrl_q;
  logic [IW-1:0]    idx;
  logic             carry, set_q, cout_q, ovf_q;
  logic [5:0]       dec_in, dec_q;
  logic             last, is_slt, is_arith;

  assign dec_in   = decode(bus.ctrl_i);
  assign dec_q    = decode(ctrl_q);
  assign last     = (idx == IW'(WIDTH - 1));
  assign is_slt   = (ctrl_q == 4'b0111);
  assign is_arith = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.sl_src1_o = 1'b0;
    bus.sl_src2_o = 1'b0;
    bus.sl_less_o = 1'b0;
    bus.sl_ainv_o = 1'b0;
    bus.sl_binv_o = 1'b0;
    bus.sl_cin_o  = 1'b0;
    bus.sl_op_o   = 2'b00;
    case (state)
      IDLE: if (bus.start_i) state_nx = dec_in[5] ? RUN : DONE;
      RUN: begin
        bus.sl_src1_o = a_q[idx];
        bus.sl_src2_o = b_q[idx];
        bus.sl_cin_o  = carry;
        bus.sl_ainv_o = dec_q[4];
        bus.sl_binv_o = dec_q[3];
        bus.sl_op_o   = dec_q[2:1];
        if (last) state_nx = is_slt ? SLT2 : DONE;
      end
      SLT2: begin
        bus.sl_src1_o = a_q[idx];
        bus.sl_src2_o = b_q[idx];
        bus.sl_cin_o  = carry;
        bus.sl_op_o   = 2'b11;
        bus.sl_less_o = (idx == '0) ? set_q : 1'b0;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      set_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          a_q      <= bus.src1_i;
          b_q      <= bus.src2_i;
          ctrl_q   <= bus.ctrl_i;
          idx      <= '0;
          carry    <= dec_in[0];
          set_q    <= 1'b0;
          result_q <= '0;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
        end
        RUN: begin
          result_q[idx] <= bus.sl_result_i;
          carry         <= bus.sl_cout_i;
          idx           <= idx + 1'b1;
          if (last) begin
            // carry still holds the carry into the MSB here
            cout_q <= (is_arith || is_slt) ? bus.sl_cout_i : 1'b0;
            ovf_q  <= is_arith ? (carry ^ bus.sl_cout_i) : 1'b0;
            set_q  <= bus.sl_result_i ^ carry ^ bus.sl_cout_i;
            idx    <= '0;
          end
        end
        SLT2: begin
          result_q[idx] <= bus.sl_result_i;
          carry         <= bus.sl_cout_i;
          idx           <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o     = (state == RUN) || (state == SLT2);
  assign bus.done_o     = (state == DONE);
  assign bus.result_o   = result_q;
  assign bus.zero_o     = (result_q == '0);
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer directly upstream of the team's 1-bit ALU slice (alu_top).
- Accepts a WIDTH-bit operation and drives the slice one bit per cycle, LSB first, through its src1/src2/less/A_invert/B_invert/cin/operation inputs.
- Captures the slice's result/cout each cycle, carrying cout into the next bit's cin.
- Assembles the WIDTH-bit result and the zero/cout/overflow flags, then signals done; it replaces a WIDTH-slice ripple array with a single slice.

Parameters:
- WIDTH, 32, operand/result width; legal range 2..64.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  request; sampled only in IDLE.
- ctrl_i  in  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
- src1_i  in  WIDTH  operand A.
- src2_i  in  WIDTH  operand B.
- busy_o  out  1  high while bits are being sequenced.
- done_o  out  1  one-cycle completion pulse.
- result_o  out  WIDTH  final result; held until next accepted start.
- zero_o  out  1  result_o == 0.
- cout_o  out  1  carry out of MSB (ADD/SUB/SLT pass 1), else 0.
- overflow_o  out  1  signed overflow (ADD/SUB), else 0.
- sl_src1_o, sl_src2_o, sl_less_o, sl_ainv_o, sl_binv_o, sl_cin_o  out  1 each  slice inputs.
- sl_op_o  out  2  slice operation.
- sl_result_i, sl_cout_i  in  1 each  slice outputs (combinational from sl_* outputs).

Behaviour:
- Reset (rst_i high at an edge, including mid-operation): state IDLE; busy_o, done_o, cout_o, overflow_o, all sl_* = 0; result_o = 0; zero_o = 1. Reset overrides start_i in the same cycle.
- States are IDLE, RUN, SLT2 and DONE.
- IDLE: on start_i = 1, latch src1_i, src2_i and ctrl_i; set bit index to 0; set carry register to the op's initial cin. Go to RUN, or to DONE for an unsupported code.
- Unsupported code: result_o = 0, zero_o = 1, flags 0, done_o one cycle after acceptance.
- Decode (ainv, binv, op, initial cin):
  - AND: 0,0,00,0
  - OR: 0,0,01,0
  - ADD: 0,0,10,0
  - SUB: 0,1,10,1
  - NOR: 1,1,00,0
  - NAND: 1,1,01,0
  - SLT pass 1: 0,1,10,1
- RUN, each cycle at index i:
  - sl_src1_o = A[i], sl_src2_o = B[i], sl_cin_o = carry register, sl_less_o = 0.
  - At the edge: result[i] <= sl_result_i; carry <= sl_cout_i; i increments.
- At i = WIDTH-1 (last bit):
  - cout_o <= sl_cout_i.
  - overflow_o <= carry_in_msb XOR sl_cout_i, for ADD/SUB only.
  - Non-SLT ops go to DONE. SLT goes to SLT2 with set = sl_result_i XOR overflow, and i reset to 0.
- SLT2: drive op = 11, ainv = binv = 0, sl_less_o = set at i = 0 and 0 elsewhere; capture result bits as in RUN. After bit WIDTH-1, go to DONE.
- SLT flags: overflow_o = 0; cout_o keeps the pass-1 value.
- DONE: done_o = 1 for exactly this cycle. result_o, zero_o and flags are valid from this cycle and held in IDLE. Next state is IDLE.
- busy_o = 1 in RUN and SLT2 only.
- start_i is ignored outside IDLE; there is no queueing.
- Latency from the accepting edge to done_o high:
  - WIDTH+1 edges for AND/OR/ADD/SUB/NOR/NAND.
  - 2*WIDTH+1 edges for SLT.
  - 1 edge for an unsupported code.
- All sl_* = 0 in IDLE and DONE.
- result_o updates bitwise during execution; only the DONE/IDLE value is architecturally valid.
- Back-to-back operation: start_i asserted during DONE is ignored. A new start is accepted in the following IDLE cycle, giving a minimum issue interval of latency + 1.

Test Plan:
- Bench wiring: instantiate alu_top connected to the sl_* ports; WIDTH=32 for all scenarios below.
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0; done exactly 33 edges after accept; busy high for 32 cycles.
- SUB 0x00000005 - 0x00000005 -> result 0, zero 1, cout 1, overflow 0. SUB 0x80000000 - 1 -> 0x7FFFFFFF, overflow 1.
- SLT 0xFFFFFFFF vs 0x00000001 -> result 0x00000001, done at edge 65. SLT 0x7FFFFFFF vs 0x80000000 -> result 0 (overflow-corrected sign).
- Logic ops, AND/OR/NOR/NAND on 0xF0F0F0F0 and 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x000F000F / 0x0FFF0FFF. Unsupported code 1111 -> result 0, zero 1, done 1 edge after accept.
- Reset and start handling:
  - rst_i asserted at edge 10 of an ADD -> next cycle all outputs at reset values, no done pulse.
  - start_i held high throughout an op -> exactly one op executes; a second is accepted only in the cycle after DONE.
